uart_line_rx: RTL and testbench
===============================

# uart_line_rx

Receive-side line assembler between the `uart` receiver outputs (`rx_rdy`, `rx_data`) and application logic. It is the reader for text lines such as "Hello, world!\r\n" that the design's transmit path emits. The block collects bytes into a `LEN`-entry line buffer, handles backspace, and terminates a line on CR or LF. It then holds the completed line for a consumer, which reads it by address and releases it with `line_ack`.

## Interface
- `LEN`, 16: line buffer depth in bytes. Must be a power of two, ≤ 256.
- `AW`, 4: address width, log2(`LEN`).

- `clk_50m`  in  1  sole clock. All logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_rdy`  in  1  byte-available from `uart`. Each 0→1 transition is one byte.
- `rx_data`  in  8  received byte. Valid on the edge where the `rx_rdy` rise is sampled.
- `line_ack`  in  1  consumer releases the held line. Ignored unless `line_rdy`=1.
- `rd_addr`  in  AW  buffer read address.
- `rd_data`  out  8  registered `buf[rd_addr]`.
- `line_rdy`  out  1  complete line held.
- `line_len`  out  AW+1  number of valid bytes, 0..`LEN`.
- `ovf`  out  1  sticky: a byte was discarded because the buffer was full.
- `drop`  out  1  sticky: a non-terminator byte arrived while a line was held.

## Operation
- Strobe generation:
  - `stb` = `rx_rdy` & ~`rx_prev`, where `rx_prev` is registered `rx_rdy`.
  - `rx_prev` resets to 1, so `rx_rdy` held high through reset does not produce a byte.
- States: FILL (reset state) and HOLD.
- FILL, on `stb`, by `rx_data`:
  - 0x0D or 0x0A, count>0: `line_rdy`←1, go to HOLD.
  - 0x0D or 0x0A, count=0: ignored. A CRLF pair therefore yields one line, and empty lines are never presented.
  - 0x08 (backspace): count←count−1 if count>0, else no-op. The buffer is not rewritten. `ovf` is unchanged.
  - Other byte, count<`LEN`: `buf[count]`←byte, count←count+1.
  - Other byte, count=`LEN`: byte discarded, `ovf`←1.
- HOLD:
  - `stb` with 0x0D or 0x0A: silently discarded.
  - `stb` with any other byte, including 0x08: discarded, `drop`←1. Buffer and count are unchanged.
  - `line_ack`=1: count←0, `ovf`←0, `drop`←0, `line_rdy`←0, go to FILL.
  - `stb` on the same edge as `line_ack`: the byte is discarded and does not set `drop`. The ack wins.
- `line_len` is the count register at all times. In FILL it shows the partial length.
- Read port: `rd_data`←`buf[rd_addr]` on every edge, in any state. Data for `rd_addr` ≥ `line_len` is unspecified.
- Widths: count is AW+1 bits and never exceeds `LEN`. There is no wrap-around.

## Timing
- Reset values: `line_rdy`=0, `line_len`=0, `ovf`=0, `drop`=0, `rd_data`=0, `rx_prev`=1, state FILL. Buffer contents are not cleared.
- Byte latency: take edge N as the first edge sampling `rx_rdy`=1 after a 0.
  - The buffer write, `line_len`, `ovf`, `drop` and `line_rdy` all update at edge N and are visible after N.
- A new byte requires `rx_rdy` low for ≥1 sampled edge between bytes.
- Read latency is 1 cycle: address applied before edge N, data valid after edge N.
- Ack: `line_ack` sampled at edge N clears the outputs after N. A byte strobed at edge N+1 is accepted into the new line.
- `rst` mid-line or in HOLD: all state returns to reset values at that edge. The partial line is lost.

## Test plan
- Send "Hello, world!\r\n" (bytes spaced ≥20 cycles):
  - `line_rdy` rises on the edge sampling '\r' with `line_len`=13.
  - `rd_addr` 0..12 returns "Hello, world!" one cycle later.
  - '\n' in HOLD leaves `drop`=0.
  - `line_ack` pulse → `line_rdy`=0, `line_len`=0 next cycle.
- Send 20 bytes "ABCDEFGHIJKLMNOPQRST" then '\r' → `line_len`=16, `ovf`=1, buffer "ABCDEFGHIJKLMNOP". Ack clears `ovf`.
- Send 0x08, "ab", 0x08, "c\r":
  - The first backspace is a no-op.
  - `line_len`=2, buffer "ac".
- Send "\r\n\r\n" alone → `line_rdy` stays 0 and `line_len` stays 0.
- Hold "hi" (after "hi\r"), then send 'x' → `drop`=1, `line_len`=2, buffer "hi". Assert `line_ack` together with the next `rx_rdy` rise → byte discarded, all flags 0.
- Hold `rx_rdy`=1 through reset release → no byte counted. Then send "abc" and assert `rst` → `line_len`=0, `line_rdy`=0, `rd_data`=0 after that edge.

Source files
------------

// File: rtl/uart_line_rx_if.sv
// rtl/uart_line_rx_if.sv - byte input, line read port and status of the line assembler
interface uart_line_rx_if #(
    parameter int LEN = 16,
    parameter int AW  = 4
);
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          line_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          line_rdy;
    logic [AW:0]   line_len;
    logic          ovf;
    logic          drop;

    modport master (
        output rx_rdy, rx_data, line_ack, rd_addr,
        input  rd_data, line_rdy, line_len, ovf, drop
    );

    modport slave (
        input  rx_rdy, rx_data, line_ack, rd_addr,
        output rd_data, line_rdy, line_len, ovf, drop
    );
endinterface

// File: rtl/uart_line_rx.sv
// rtl/uart_line_rx.sv - collects uart bytes into a held text line with backspace and CR/LF termination
module uart_line_rx #(
    parameter int LEN = 16,
    parameter int AW  = 4
) (
    input  logic          clk_50m,
    input  logic          rst,
    uart_line_rx_if.slave bus
);
    localparam logic [AW:0] FULL = (AW+1)'(LEN);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t      state;
    logic        rx_prev;
    logic [AW:0] count;
    logic        line_rdy;
    logic        ovf;
    logic        drop;
    logic [7:0]  rd_data;
    logic [7:0]  mem [LEN];

    logic stb;
    logic is_term;
    logic is_bs;
    logic wr_en;

    // rx_prev resets high so a level already asserted at reset release is not a byte
    assign stb     = bus.rx_rdy & ~rx_prev;
    assign is_term = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    assign is_bs   = (bus.rx_data == 8'h08);
    assign wr_en   = !rst && (state == FILL) && stb && !is_term && !is_bs && (count != FULL);

    always_ff @(posedge clk_50m) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[bus.rd_addr];
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state    <= FILL;
            rx_prev  <= 1'b1;
            count    <= '0;
            line_rdy <= 1'b0;
            ovf      <= 1'b0;
            drop     <= 1'b0;
        end else begin
            rx_prev <= bus.rx_rdy;
            case (state)
                FILL: begin
                    if (stb) begin
                        if (is_term) begin
                            // empty lines (e.g. the LF of a CRLF pair) are swallowed
                            if (count != '0) begin
                                line_rdy <= 1'b1;
                                state    <= HOLD;
                            end
                        end else if (is_bs) begin
                            if (count != '0) begin
                                count <= count - ONE;
                            end
                        end else if (count != FULL) begin
                            count <= count + ONE;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // an ack on the same edge as a strobe wins; the byte vanishes quietly
                    if (bus.line_ack) begin
                        count    <= '0;
                        ovf      <= 1'b0;
                        drop     <= 1'b0;
                        line_rdy <= 1'b0;
                        state    <= FILL;
                    end else if (stb && !is_term) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.line_rdy = line_rdy;
    assign bus.line_len = count;
    assign bus.ovf      = ovf;
    assign bus.drop     = drop;
endmodule

// File: tb/tb_uart_line_rx.sv
// tb/tb_uart_line_rx.sv - directed bench for uart_line_rx with a line-level reference model
module tb_uart_line_rx;
    localparam int LEN = 16;
    localparam int AW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_line_rx_if #(.LEN(LEN), .AW(AW)) bus ();

    uart_line_rx #(.LEN(LEN), .AW(AW)) dut (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // inputs as seen by the DUT at each rising edge
    logic          s_rst, s_rx_rdy, s_ack;
    logic [7:0]    s_data;
    logic [AW-1:0] s_addr;
    bit            cap_ok = 1'b0;

    always @(posedge clk) begin
        s_rst    <= rst;
        s_rx_rdy <= bus.rx_rdy;
        s_ack    <= bus.line_ack;
        s_data   <= bus.rx_data;
        s_addr   <= bus.rd_addr;
        cap_ok   <= 1'b1;
    end

    // reference: the line is a byte queue, the flags are plain bits
    logic [7:0] m_line [$];
    bit         m_hold, m_ovf, m_drop, m_prev;
    bit         rd_known;
    logic [7:0] rd_exp;

    initial begin
        bit stb;
        forever begin
            @(negedge clk);
            if (!cap_ok) continue;
            if (s_rst) begin
                m_line.delete();
                m_hold = 0; m_ovf = 0; m_drop = 0; m_prev = 1;
                rd_known = 1; rd_exp = 8'h00;
            end else begin
                stb = s_rx_rdy && !m_prev;
                m_prev = s_rx_rdy;
                rd_known = (int'(s_addr) < m_line.size());
                if (rd_known) rd_exp = m_line[s_addr];
                if (m_hold) begin
                    if (s_ack) begin
                        m_line.delete();
                        m_hold = 0; m_ovf = 0; m_drop = 0;
                    end else if (stb && s_data != 8'h0D && s_data != 8'h0A) begin
                        m_drop = 1;
                    end
                end else if (stb) begin
                    if (s_data == 8'h0D || s_data == 8'h0A) begin
                        if (m_line.size() > 0) m_hold = 1;
                    end else if (s_data == 8'h08) begin
                        if (m_line.size() > 0) void'(m_line.pop_back());
                    end else if (m_line.size() < LEN) begin
                        m_line.push_back(s_data);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            check("m_line_rdy", 32'(bus.line_rdy), 32'(m_hold));
            check("m_line_len", 32'(bus.line_len), 32'(m_line.size()));
            check("m_ovf", 32'(bus.ovf), 32'(m_ovf));
            check("m_drop", 32'(bus.drop), 32'(m_drop));
            if (rd_known) check("m_rd_data", 32'(bus.rd_data), 32'(rd_exp));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // rx_rdy is high for exactly one sampled edge; returns just after that edge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        @(negedge clk);
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            idle(gap);
        end
    endtask

    task automatic read_chk(input int addr, input logic [7:0] exp, input string name);
        bus.rd_addr = AW'(addr);
        @(negedge clk);
        check(name, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic ack();
        bus.line_ack = 1'b1;
        @(negedge clk);
        bus.line_ack = 1'b0;
    endtask

    initial begin
        string hello;
        string alpha;
        hello = "Hello, world!";
        alpha = "ABCDEFGHIJKLMNOPQRST";
        bus.rx_rdy = 1'b0; bus.rx_data = 8'h00; bus.line_ack = 1'b0; bus.rd_addr = '0;

        idle(3);
        check("rst_line_rdy", 32'(bus.line_rdy), 0);
        check("rst_line_len", 32'(bus.line_len), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        check("rst_drop", 32'(bus.drop), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        rst = 1'b0;
        idle(2);

        send_str(hello, 20);
        send_byte(8'h0D);
        check("hello_rdy_at_cr", 32'(bus.line_rdy), 1);
        check("hello_len", 32'(bus.line_len), 13);
        idle(20);
        send_byte(8'h0A);
        idle(20);
        check("hello_lf_no_drop", 32'(bus.drop), 0);
        check("hello_still_held", 32'(bus.line_rdy), 1);
        for (int i = 0; i < 13; i++) read_chk(i, hello[i], "hello_rd");
        ack();
        check("hello_ack_rdy", 32'(bus.line_rdy), 0);
        check("hello_ack_len", 32'(bus.line_len), 0);

        send_str(alpha, 2);
        send_byte(8'h0D);
        check("ovf_len", 32'(bus.line_len), 16);
        check("ovf_flag", 32'(bus.ovf), 1);
        check("ovf_rdy", 32'(bus.line_rdy), 1);
        for (int i = 0; i < 16; i++) read_chk(i, alpha[i], "ovf_rd");
        ack();
        check("ovf_ack_clear", 32'(bus.ovf), 0);

        send_byte(8'h08);
        check("bs_empty_noop", 32'(bus.line_len), 0);
        send_str("ab", 1);
        send_byte(8'h08);
        check("bs_len_after_bs", 32'(bus.line_len), 1);
        send_str("c\r", 1);
        check("bs_len", 32'(bus.line_len), 2);
        read_chk(0, "a", "bs_rd0");
        read_chk(1, "c", "bs_rd1");
        ack();

        send_str("\r\n\r\n", 2);
        check("empty_rdy", 32'(bus.line_rdy), 0);
        check("empty_len", 32'(bus.line_len), 0);

        send_str("hi\r", 2);
        send_byte("x");
        check("drop_flag", 32'(bus.drop), 1);
        check("drop_len", 32'(bus.line_len), 2);
        read_chk(0, "h", "drop_rd0");
        read_chk(1, "i", "drop_rd1");
        @(negedge clk);
        bus.line_ack = 1'b1; bus.rx_rdy = 1'b1; bus.rx_data = "y";
        @(negedge clk);
        bus.line_ack = 1'b0; bus.rx_rdy = 1'b0;
        check("ackwin_drop", 32'(bus.drop), 0);
        check("ackwin_len", 32'(bus.line_len), 0);
        check("ackwin_rdy", 32'(bus.line_rdy), 0);
        check("ackwin_ovf", 32'(bus.ovf), 0);
        send_byte("z");
        check("after_ack_accept", 32'(bus.line_len), 1);

        rst = 1'b1; bus.rx_rdy = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);
        check("rxhigh_no_byte", 32'(bus.line_len), 0);
        bus.rx_rdy = 1'b0;
        send_str("abc", 1);
        check("abc_len", 32'(bus.line_len), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_len", 32'(bus.line_len), 0);
        check("midrst_rdy", 32'(bus.line_rdy), 0);
        check("midrst_rd_data", 32'(bus.rd_data), 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
